// File: rtl/sram_req_rsp_ctrl.sv
// sram_req_rsp_ctrl
// Byte-writable synchronous SRAM with a valid/ready request port and an
// in-order read-response FIFO so the consumer can stall without losing data.
// A read is sampled from the array at its accepting edge, held for one cycle
// as "in flight", then pushed into the response FIFO on the following edge.
// Optional feature macro: SRAM_PARITY_EN (one even-parity bit per byte).
module sram_req_rsp_ctrl #(
  parameter int DATA_W    = 32,
  parameter int ADDR_W    = 14,
  parameter int RSP_DEPTH = 2
) (
  input  logic                  CK,
  input  logic                  RSTn,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [DATA_W/8-1:0]   req_web,
  input  logic [ADDR_W-1:0]     req_addr,
  input  logic [DATA_W-1:0]     req_wdata,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_W-1:0]     rsp_rdata,
  output logic                  rsp_perr
);

  localparam int BYTES = DATA_W / 8;
  localparam int DEPTH = 2 ** ADDR_W;
  localparam int PTR_W = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;
  localparam int CNT_W = $clog2(RSP_DEPTH + 1);

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [DATA_W-1:0] r_fifoData [RSP_DEPTH];
  logic              r_fifoPerr [RSP_DEPTH];

  logic              r_inflight;
  logic [DATA_W-1:0] r_rdData;
  logic              r_rdPerr;
  logic [PTR_W-1:0]  r_wrPtr;
  logic [PTR_W-1:0]  r_rdPtr;
  logic [CNT_W-1:0]  r_count;
  logic [DATA_W-1:0] r_rspData;
  logic              r_rspPerr;

  logic              w_isRead;
  logic              w_rdAccept;
  logic              w_wrAccept;
  logic              w_push;
  logic              w_pop;
  logic              w_rdPerr;
  logic [CNT_W:0]    w_occupancy;
  logic [CNT_W-1:0]  w_countNext;
  logic [PTR_W-1:0]  w_rdPtrNext;
  logic [DATA_W-1:0] w_headData;
  logic              w_headPerr;

  // Pointers wrap at RSP_DEPTH, which need not be a power of two.
  function automatic logic [PTR_W-1:0] incPtr(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(RSP_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // A request slot is only granted when its response is guaranteed FIFO room,
  // counting the read still in flight; this is what keeps count <= RSP_DEPTH.
  assign w_occupancy = {1'b0, r_count} + {{CNT_W{1'b0}}, r_inflight};
  assign req_ready   = w_occupancy < (CNT_W + 1)'(RSP_DEPTH);
  assign w_isRead    = &req_web;
  assign w_rdAccept  = req_valid & req_ready & w_isRead;
  assign w_wrAccept  = req_valid & req_ready & ~w_isRead;
  assign w_push      = r_inflight;
  assign w_pop       = (r_count != '0) & rsp_ready;

  assign rsp_valid = (r_count != '0);
  assign rsp_rdata = r_rspData;
  assign rsp_perr  = r_rspPerr;

  // Byte-masked array write; the array itself is deliberately never reset.
  always_ff @(posedge CK) begin
    for (int b = 0; b < BYTES; b++) begin
      if (w_wrAccept && !req_web[b]) begin
        r_mem[req_addr][8*b +: 8] <= req_wdata[8*b +: 8];
      end
    end
  end

`ifdef SRAM_PARITY_EN
  logic [BYTES-1:0] r_par [DEPTH];

  // Even parity per byte, refreshed only for the bytes actually written.
  always_ff @(posedge CK) begin
    for (int b = 0; b < BYTES; b++) begin
      if (w_wrAccept && !req_web[b]) begin
        r_par[req_addr][b] <= ^req_wdata[8*b +: 8];
      end
    end
  end

  // Any byte whose recomputed parity disagrees with the stored bit flags the read.
  always_comb begin
    w_rdPerr = 1'b0;
    for (int b = 0; b < BYTES; b++) begin
      if ((^r_mem[req_addr][8*b +: 8]) != r_par[req_addr][b]) begin
        w_rdPerr = 1'b1;
      end
    end
  end
`else
  assign w_rdPerr = 1'b0;
`endif

  // Next occupancy and head pointer after this edge's push/pop.
  always_comb begin
    w_countNext = r_count;
    case ({w_push, w_pop})
      2'b10:   w_countNext = r_count + 1'b1;
      2'b01:   w_countNext = r_count - 1'b1;
      default: w_countNext = r_count;
    endcase
    w_rdPtrNext = w_pop ? incPtr(r_rdPtr) : r_rdPtr;
  end

  // Registered head view: the new head entry (possibly the word being pushed
  // right now) or the previous value held when the FIFO drains empty.
  always_comb begin
    w_headData = r_rspData;
    w_headPerr = r_rspPerr;
    if (w_countNext != '0) begin
      if (w_push && (w_rdPtrNext == r_wrPtr)) begin
        w_headData = r_rdData;
        w_headPerr = r_rdPerr;
      end else begin
        w_headData = r_fifoData[w_rdPtrNext];
        w_headPerr = r_fifoPerr[w_rdPtrNext];
      end
    end
  end

  // FIFO storage slots hold no control meaning, so they need no reset.
  always_ff @(posedge CK) begin
    if (w_push) begin
      r_fifoData[r_wrPtr] <= r_rdData;
      r_fifoPerr[r_wrPtr] <= r_rdPerr;
    end
  end

  // Read pipeline stage, FIFO bookkeeping and the registered response head.
  always_ff @(posedge CK or negedge RSTn) begin
    if (!RSTn) begin
      r_inflight <= 1'b0;
      r_rdData   <= '0;
      r_rdPerr   <= 1'b0;
      r_wrPtr    <= '0;
      r_rdPtr    <= '0;
      r_count    <= '0;
      r_rspData  <= '0;
      r_rspPerr  <= 1'b0;
    end else begin
      r_inflight <= w_rdAccept;
      if (w_rdAccept) begin
        r_rdData <= r_mem[req_addr];
        r_rdPerr <= w_rdPerr;
      end
      if (w_push) begin
        r_wrPtr <= incPtr(r_wrPtr);
      end
      r_rdPtr   <= w_rdPtrNext;
      r_count   <= w_countNext;
      r_rspData <= w_headData;
      r_rspPerr <= w_headPerr;
    end
  end

endmodule

// File: tb/tb_sram_req_rsp_ctrl.sv
// tb_sram_req_rsp_ctrl
// Directed bench for sram_req_rsp_ctrl. Reads push their hand-computed
// expected response into a queue when accepted; an independent monitor pops
// and compares whenever a response is consumed. Build with +define+SRAM_PARITY_EN
// to expect parity flags on the corrupted word.
module tb_sram_req_rsp_ctrl;

  logic        CK = 1'b0;
  logic        RSTn;
  logic        req_valid;
  logic        req_ready;
  logic [3:0]  req_web;
  logic [13:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_perr;

  typedef struct packed {
    logic [31:0] data;
    logic        perr;
  } rsp_t;

  rsp_t expQ[$];
  int   checks = 0;
  int   errors = 0;

`ifdef SRAM_PARITY_EN
  localparam logic PERR_EXP = 1'b1;
`else
  localparam logic PERR_EXP = 1'b0;
`endif

  sram_req_rsp_ctrl #(.DATA_W(32), .ADDR_W(14), .RSP_DEPTH(2)) dut (
    .CK        (CK),
    .RSTn      (RSTn),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_web   (req_web),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_rdata (rsp_rdata),
    .rsp_perr  (rsp_perr)
  );

  always #5 CK = ~CK;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] required);
    checks++;
    if (actual !== required) begin
      errors++;
      $display("[TB] FAIL %s actual=%h required=%h at %0t", name, actual, required, $time);
    end
  endtask

  // Issue one request, waiting a bounded time for req_ready; reads record their expected response.
  task automatic applyStimulus(input logic [3:0] web, input logic [13:0] addr,
                               input logic [31:0] wdata, input logic [31:0] expData,
                               input logic expPerr);
    bit accepted = 0;
    int waitCycles = 0;
    req_valid = 1'b1;
    req_web   = web;
    req_addr  = addr;
    req_wdata = wdata;
    while (!accepted && waitCycles < 50) begin
      @(negedge CK);
      if (req_ready) accepted = 1;
      else waitCycles++;
    end
    if (!accepted) begin
      checks++;
      errors++;
      $display("[TB] FAIL req_accept_timeout addr=%h actual=not_accepted required=accepted", addr);
    end else if (&web) begin
      expQ.push_back('{data: expData, perr: expPerr});
    end
    @(posedge CK);
    #1;
    req_valid = 1'b0;
  endtask

  // Monitor: every consumed response is compared against the oldest expectation.
  always @(negedge CK) begin
    if (RSTn && rsp_valid && rsp_ready) begin
      if (expQ.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL unexpected_rsp actual=%h required=no_response", rsp_rdata);
      end else begin
        rsp_t exp;
        exp = expQ.pop_front();
        checkOutput("rsp_rdata", rsp_rdata, exp.data);
        checkOutput("rsp_perr", {31'b0, rsp_perr}, {31'b0, exp.perr});
      end
    end
  end

  initial begin
    int waitCycles;
    RSTn      = 1'b0;
    req_valid = 1'b0;
    req_web   = 4'hF;
    req_addr  = '0;
    req_wdata = '0;
    rsp_ready = 1'b1;

    #1;
    checkOutput("reset_rsp_valid", {31'b0, rsp_valid}, 32'd0);
    checkOutput("reset_rsp_rdata", rsp_rdata, 32'd0);
    checkOutput("reset_req_ready", {31'b0, req_ready}, 32'd1);
    repeat (2) @(posedge CK);
    #1;
    RSTn = 1'b1;
    @(posedge CK);
    #1;

    $display("[TB] T2 write then read-after-write");
    applyStimulus(4'b0000, 14'h0010, 32'hDEADBEEF, 32'h0, 1'b0);
    applyStimulus(4'b1111, 14'h0010, 32'h0, 32'hDEADBEEF, 1'b0);
    @(negedge CK);
    checkOutput("t2_latency_not_yet", {31'b0, rsp_valid}, 32'd0);
    @(negedge CK);
    checkOutput("t2_latency_valid", {31'b0, rsp_valid}, 32'd1);
    @(posedge CK);
    #1;

    $display("[TB] T3 byte write");
    applyStimulus(4'b1110, 14'h0010, 32'h000000AA, 32'h0, 1'b0);
    applyStimulus(4'b1111, 14'h0010, 32'h0, 32'hDEADBEAA, 1'b0);

    $display("[TB] T5 address extremes");
    applyStimulus(4'b0000, 14'h3FFF, 32'h11111111, 32'h0, 1'b0);
    applyStimulus(4'b0000, 14'h0000, 32'h22222222, 32'h0, 1'b0);
    applyStimulus(4'b1111, 14'h3FFF, 32'h0, 32'h11111111, 1'b0);
    applyStimulus(4'b1111, 14'h0000, 32'h0, 32'h22222222, 1'b0);

    $display("[TB] T4 backpressure");
    applyStimulus(4'b0000, 14'h0001, 32'hA1A1A1A1, 32'h0, 1'b0);
    applyStimulus(4'b0000, 14'h0002, 32'hB2B2B2B2, 32'h0, 1'b0);
    applyStimulus(4'b0000, 14'h0003, 32'hC3C3C3C3, 32'h0, 1'b0);
    repeat (4) @(posedge CK);
    #1;
    rsp_ready = 1'b0;
    applyStimulus(4'b1111, 14'h0001, 32'h0, 32'hA1A1A1A1, 1'b0);
    applyStimulus(4'b1111, 14'h0002, 32'h0, 32'hB2B2B2B2, 1'b0);
    fork
      applyStimulus(4'b1111, 14'h0003, 32'h0, 32'hC3C3C3C3, 1'b0);
      begin
        @(posedge CK);
        #2;
        checkOutput("t4_req_ready_full", {31'b0, req_ready}, 32'd0);
        checkOutput("t4_rsp_valid_held", {31'b0, rsp_valid}, 32'd1);
        @(posedge CK);
        #2;
        checkOutput("t4_req_ready_still_full", {31'b0, req_ready}, 32'd0);
        rsp_ready = 1'b1;
      end
    join

    $display("[TB] T6 parity deposit");
    applyStimulus(4'b0000, 14'h0020, 32'hCAFEF00D, 32'h0, 1'b0);
    dut.r_mem[14'h0020] = 32'hCAFEF10D;
    applyStimulus(4'b1111, 14'h0020, 32'h0, 32'hCAFEF10D, PERR_EXP);
    applyStimulus(4'b1111, 14'h0010, 32'h0, 32'hDEADBEAA, 1'b0);

    waitCycles = 0;
    while (expQ.size() != 0 && waitCycles < 100) begin
      @(posedge CK);
      waitCycles++;
    end
    checkOutput("drain_pending", expQ.size(), 32'd0);
    #1;

    $display("[TB] T1 reset mid-read");
    rsp_ready = 1'b0;
    applyStimulus(4'b1111, 14'h0010, 32'h0, 32'hDEADBEAA, 1'b0);
    @(posedge CK);
    #1;
    checkOutput("t1_pre_rsp_rdata", rsp_rdata, 32'hDEADBEAA);
    req_valid = 1'b1;
    req_web   = 4'b1111;
    req_addr  = 14'h0000;
    @(posedge CK);
    #1;
    req_valid = 1'b0;
    RSTn = 1'b0;
    #1;
    expQ.delete();
    checkOutput("t1_rsp_valid", {31'b0, rsp_valid}, 32'd0);
    checkOutput("t1_rsp_rdata", rsp_rdata, 32'd0);
    checkOutput("t1_rsp_perr", {31'b0, rsp_perr}, 32'd0);
    checkOutput("t1_req_ready", {31'b0, req_ready}, 32'd1);
    #2;
    RSTn = 1'b1;
    rsp_ready = 1'b1;
    repeat (4) begin
      @(negedge CK);
      checkOutput("t1_no_stale_rsp", {31'b0, rsp_valid}, 32'd0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
